// File: rtl/wb_gpio_bank.sv
// wb_gpio_bank: WIDTH-bit Wishbone GPIO bank with per-pin output data and
// direction, synchronised inputs and atomic set/clear writes.
// Optional edge-detect interrupts are built when GPIO_IRQ_EN is defined;
// otherwise addresses 3..5 read 0, ignore writes, and o_irq is tied low.
module wb_gpio_bank #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int RST_OUT     = 0
) (
    input  logic             i_wb_clk,
    input  logic             i_wb_rst,
    input  logic [2:0]       i_wb_adr,
    input  logic [31:0]      i_wb_dat,
    input  logic [3:0]       i_wb_sel,
    input  logic             i_wb_we,
    input  logic             i_wb_stb,
    output logic [31:0]      o_wb_rdt,
    output logic             o_wb_ack,
    input  logic [WIDTH-1:0] i_gpio,
    output logic [WIDTH-1:0] o_gpio,
    output logic [WIDTH-1:0] o_gpio_oe,
    output logic             o_irq
);

    localparam logic [WIDTH-1:0] RST_PAT = ((RST_OUT & 1) != 0) ? '1 : '0;

    localparam logic [2:0] ADR_DATA_OUT = 3'd0;
    localparam logic [2:0] ADR_DIR      = 3'd1;
    localparam logic [2:0] ADR_DATA_IN  = 3'd2;
    localparam logic [2:0] ADR_RISE_EN  = 3'd3;
    localparam logic [2:0] ADR_FALL_EN  = 3'd4;
    localparam logic [2:0] ADR_STATUS   = 3'd5;
    localparam logic [2:0] ADR_SET      = 3'd6;
    localparam logic [2:0] ADR_CLR      = 3'd7;

    logic [31:0]      lane_mask;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] wbits;
    logic             wr;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] rd_bits;
    logic [31:0]      rd_word;
    logic             unused_bits;

    assign lane_mask = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}},
                        {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};
    assign wmask     = lane_mask[WIDTH-1:0];
    assign wbits     = i_wb_dat[WIDTH-1:0] & wmask;
    // Side effects only on the ack cycle, so each transaction commits once.
    assign wr        = i_wb_stb & i_wb_we & o_wb_ack;
    assign sync_in   = sync_q[SYNC_STAGES-1];
    // Upper data/lane bits are intentionally dropped when WIDTH < 32.
    assign unused_bits = ^{i_wb_dat, lane_mask};

    assign o_gpio    = data_out;
    assign o_gpio_oe = dir;

    // Input synchroniser chain; sync_in is the last stage.
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= i_gpio;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // Output data and direction registers, including atomic set/clear.
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            data_out <= RST_PAT;
            dir      <= '0;
        end else if (wr) begin
            case (i_wb_adr)
                ADR_DATA_OUT: data_out <= (data_out & ~wmask) | wbits;
                ADR_DIR:      dir      <= (dir & ~wmask) | wbits;
                ADR_SET:      data_out <= data_out | wbits;
                ADR_CLR:      data_out <= data_out & ~wbits;
                default: ;
            endcase
        end
    end

`ifdef GPIO_IRQ_EN
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] status;
    logic [WIDTH-1:0] edge_ev;
    logic [WIDTH-1:0] w1c;
    logic             irq_q;

    assign edge_ev = (sync_in & ~prev & rise_en) | (~sync_in & prev & fall_en);
    assign w1c     = (wr && i_wb_adr == ADR_STATUS) ? wbits : '0;
    assign o_irq   = irq_q;

    // Edge history, enables and sticky status; a new event beats a same-cycle clear.
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            prev    <= '0;
            rise_en <= '0;
            fall_en <= '0;
            status  <= '0;
            irq_q   <= 1'b0;
        end else begin
            prev   <= sync_in;
            status <= (status & ~w1c) | edge_ev;
            irq_q  <= |status;
            if (wr && i_wb_adr == ADR_RISE_EN) rise_en <= (rise_en & ~wmask) | wbits;
            if (wr && i_wb_adr == ADR_FALL_EN) fall_en <= (fall_en & ~wmask) | wbits;
        end
    end
`else
    assign o_irq = 1'b0;
`endif

    // Read multiplexer; unused and write-only addresses return 0.
    always_comb begin
        rd_bits = '0;
        case (i_wb_adr)
            ADR_DATA_OUT: rd_bits = data_out;
            ADR_DIR:      rd_bits = dir;
            ADR_DATA_IN:  rd_bits = sync_in;
`ifdef GPIO_IRQ_EN
            ADR_RISE_EN:  rd_bits = rise_en;
            ADR_FALL_EN:  rd_bits = fall_en;
            ADR_STATUS:   rd_bits = status;
`endif
            default:      rd_bits = '0;
        endcase
        rd_word = '0;
        rd_word[WIDTH-1:0] = rd_bits;
    end

    // Single-cycle ack; read data captured on the stb cycle, zero otherwise.
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            o_wb_ack <= 1'b0;
            o_wb_rdt <= '0;
        end else begin
            o_wb_ack <= i_wb_stb & ~o_wb_ack;
            o_wb_rdt <= (i_wb_stb & ~o_wb_ack) ? rd_word : '0;
        end
    end

endmodule
